// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_scheduler
// Brief    : NUM_OBS-slot obstacle spawner/scroller with gap spacing and an
//            optional speed ramp (enabled by defining OBS_SPEEDUP_EN).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module obstacle_scheduler #(
    parameter int NUM_OBS       = 2,
    parameter int XW            = 8,
    parameter int SCREEN_X      = 160,
    parameter int MIN_GAP       = 40,
    parameter int NUM_TYPES     = 5,
    parameter int SPEED_MAX     = 4,
    parameter int SPEEDUP_TICKS = 600
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  game_tick,
    input  logic                  game_start,
    input  logic                  game_over,
    input  logic [7:0]            rng,
    output logic [NUM_OBS*XW-1:0] obs_pos,
    output logic [NUM_OBS*3-1:0]  obs_type,
    output logic [NUM_OBS-1:0]    obs_active,
    output logic [2:0]            speed
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam logic [XW-1:0] C_SCREEN   = XW'(SCREEN_X);
    localparam logic [XW-1:0] C_SPAWN_X  = XW'(SCREEN_X - 1);
    localparam logic [8:0]    C_MIN_GAP  = 9'(MIN_GAP);
    localparam logic [3:0]    C_NTYPES   = 4'(NUM_TYPES);

    state_t                        r_state;
    logic [NUM_OBS-1:0][XW-1:0]    r_pos;
    logic [NUM_OBS-1:0][2:0]       r_type;
    logic [NUM_OBS-1:0]            r_active;
    logic [8:0]                    r_gap_acc;
    logic [8:0]                    r_gap_target;
    logic [2:0]                    w_speed;

    logic [NUM_OBS-1:0][XW-1:0]    w_pos_scr;
    logic [NUM_OBS-1:0]            w_act_scr;
    logic [NUM_OBS-1:0]            w_spawn_mask;
    logic                          w_spawn;
    logic [9:0]                    w_gap_sum;
    logic [8:0]                    w_gap_sat;
    logic [2:0]                    w_type_new;
    logic [8:0]                    w_target_new;

`ifdef OBS_SPEEDUP_EN
    logic [2:0]  r_speed;
    logic [11:0] r_speed_cnt;
    logic        w_ramp_wrap;
    logic [2:0]  w_speed_up;

    assign w_speed     = r_speed;
    assign w_ramp_wrap = (r_speed_cnt == 12'(SPEEDUP_TICKS - 1));
    assign w_speed_up  = (r_speed < 3'(SPEED_MAX)) ? r_speed + 3'd1 : r_speed;
`else
    assign w_speed = 3'd1;
`endif

    // Scroll each slot using the pre-tick speed; retirement avoids underflow.
    generate
        for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_slot
            always_comb begin
                w_pos_scr[gi] = C_SCREEN;
                w_act_scr[gi] = 1'b0;
                if (r_active[gi] && (r_pos[gi] >= {{(XW-3){1'b0}}, w_speed})) begin
                    w_pos_scr[gi] = r_pos[gi] - {{(XW-3){1'b0}}, w_speed};
                    w_act_scr[gi] = 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        w_spawn_mask = '0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (!w_act_scr[i]) begin
                w_spawn_mask    = '0;
                w_spawn_mask[i] = 1'b1;
            end
        end
    end

    assign w_spawn      = (r_gap_acc >= r_gap_target) && (|w_spawn_mask);
    assign w_gap_sum    = {1'b0, r_gap_acc} + {7'd0, w_speed};
    assign w_gap_sat    = w_gap_sum[9] ? 9'h1FF : w_gap_sum[8:0];
    assign w_type_new   = ({1'b0, rng[2:0]} < C_NTYPES) ? rng[2:0]
                                                         : rng[2:0] - C_NTYPES[2:0];
    assign w_target_new = C_MIN_GAP + {4'd0, rng[7:3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pos        <= {NUM_OBS{C_SCREEN}};
            r_type       <= '0;
            r_active     <= '0;
            r_gap_acc    <= '0;
            r_gap_target <= C_MIN_GAP;
`ifdef OBS_SPEEDUP_EN
            r_speed      <= 3'd1;
            r_speed_cnt  <= '0;
`endif
        end else begin
            // Restart: from IDLE/FROZEN start wins, in RUN game_over wins.
            if (game_start && !(r_state == RUN && game_over)) begin
                r_state      <= RUN;
                r_pos        <= {NUM_OBS{C_SCREEN}};
                r_type       <= '0;
                r_active     <= '0;
                r_gap_acc    <= C_MIN_GAP;
                r_gap_target <= C_MIN_GAP;
`ifdef OBS_SPEEDUP_EN
                r_speed      <= 3'd1;
                r_speed_cnt  <= '0;
`endif
            end else if (r_state == RUN && game_over) begin
                r_state <= FROZEN;
            end else if (r_state == RUN && game_tick) begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (w_spawn && w_spawn_mask[i]) begin
                        r_pos[i]    <= C_SPAWN_X;
                        r_active[i] <= 1'b1;
                        r_type[i]   <= w_type_new;
                    end else begin
                        r_pos[i]    <= w_pos_scr[i];
                        r_active[i] <= w_act_scr[i];
                    end
                end
                if (w_spawn) begin
                    r_gap_acc    <= '0;
                    r_gap_target <= w_target_new;
                end else begin
                    r_gap_acc    <= w_gap_sat;
                end
`ifdef OBS_SPEEDUP_EN
                if (w_ramp_wrap) begin
                    r_speed_cnt <= '0;
                    r_speed     <= w_speed_up;
                end else begin
                    r_speed_cnt <= r_speed_cnt + 12'd1;
                end
`endif
            end
        end
    end

    assign obs_pos    = r_pos;
    assign obs_type   = r_type;
    assign obs_active = r_active;
    assign speed      = w_speed;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_scheduler
// Brief    : Directed self-checking bench for obstacle_scheduler (NUM_OBS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_tick = 1'b0;
    logic        game_start = 1'b0;
    logic        game_over = 1'b0;
    logic [7:0]  rng = 8'h00;
    logic [15:0] obs_pos;
    logic [5:0]  obs_type;
    logic [1:0]  obs_active;
    logic [2:0]  speed;

    int checks = 0;
    int errors = 0;

    obstacle_scheduler #(
        .NUM_OBS(2), .XW(8), .SCREEN_X(160), .MIN_GAP(40),
        .NUM_TYPES(5), .SPEED_MAX(4), .SPEEDUP_TICKS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_start(game_start),
        .game_over(game_over), .rng(rng), .obs_pos(obs_pos), .obs_type(obs_type),
        .obs_active(obs_active), .speed(speed)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n, input logic [7:0] r);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            game_tick = 1'b1;
            rng = r;
            @(negedge clk);
            game_tick = 1'b0;
        end
    endtask

    task automatic pulse(input logic s, input logic o, input logic t);
        @(negedge clk);
        game_start = s;
        game_over  = o;
        game_tick  = t;
        @(negedge clk);
        game_start = 1'b0;
        game_over  = 1'b0;
        game_tick  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (obs_active !== 2'b00 || obs_pos !== {8'd160, 8'd160} || obs_type !== 6'd0 || speed !== 3'd1) begin
            errors++;
            $display("FAIL reset_values act=%b pos=%h type=%h spd=%0d want act=00 pos=a0a0 type=00 spd=1",
                     obs_active, obs_pos, obs_type, speed);
        end
        ticks(10, 8'hFF);
        checks++;
        if (obs_active !== 2'b00 || obs_pos !== {8'd160, 8'd160} || speed !== 3'd1) begin
            errors++;
            $display("FAIL idle_ticks act=%b pos=%h spd=%0d want act=00 pos=a0a0 spd=1",
                     obs_active, obs_pos, speed);
        end
    endtask

    task automatic test_spawn;
        pulse(1'b1, 1'b0, 1'b0);
        ticks(1, 8'h0A);
        checks++;
        if (obs_active !== 2'b01 || obs_pos[7:0] !== 8'd159 || obs_type[2:0] !== 3'd2 || obs_pos[15:8] !== 8'd160) begin
            errors++;
            $display("FAIL first_spawn act=%b pos=%h type0=%0d want act=01 pos=a09f type0=2",
                     obs_active, obs_pos, obs_type[2:0]);
        end
        ticks(1, 8'h0A);
        checks++;
        if (obs_pos[7:0] !== 8'd158) begin
            errors++;
            $display("FAIL scroll_one got %0d want 158", obs_pos[7:0]);
        end
        // Target is 41 here, so 41 ticks after the spawn must not yet spawn.
        ticks(40, 8'h0A);
        checks++;
        if (obs_active !== 2'b01 || obs_pos[7:0] !== 8'd118) begin
            errors++;
            $display("FAIL gap_target_41 act=%b pos0=%0d want act=01 pos0=118", obs_active, obs_pos[7:0]);
        end
        ticks(1, 8'h07);
        checks++;
        if (obs_active !== 2'b11 || obs_pos[15:8] !== 8'd159 || obs_type[5:3] !== 3'd2 || obs_pos[7:0] !== 8'd117) begin
            errors++;
            $display("FAIL second_spawn act=%b pos=%h type1=%0d want act=11 pos=9f75 type1=2",
                     obs_active, obs_pos, obs_type[5:3]);
        end
    endtask

    task automatic test_full_slots;
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_active !== 2'b00 || obs_pos !== {8'd160, 8'd160}) begin
            errors++;
            $display("FAIL restart_in_run act=%b pos=%h want act=00 pos=a0a0", obs_active, obs_pos);
        end
        ticks(1, 8'h00);
        ticks(41, 8'h00);
        checks++;
        if (obs_active !== 2'b11 || obs_pos !== {8'd159, 8'd118}) begin
            errors++;
            $display("FAIL gap40_spawn act=%b pos=%h want act=11 pos=9f76", obs_active, obs_pos);
        end
        ticks(41, 8'h00);
        checks++;
        if (obs_active !== 2'b11 || obs_pos !== {8'd118, 8'd77}) begin
            errors++;
            $display("FAIL no_free_slot act=%b pos=%h want act=11 pos=764d", obs_active, obs_pos);
        end
        ticks(77, 8'h00);
        checks++;
        if (obs_active !== 2'b11 || obs_pos !== {8'd41, 8'd0}) begin
            errors++;
            $display("FAIL reach_zero act=%b pos=%h want act=11 pos=2900", obs_active, obs_pos);
        end
        ticks(1, 8'h06);
        checks++;
        if (obs_active !== 2'b11 || obs_pos !== {8'd40, 8'd159} || obs_type[2:0] !== 3'd1) begin
            errors++;
            $display("FAIL retire_respawn act=%b pos=%h type0=%0d want act=11 pos=289f type0=1",
                     obs_active, obs_pos, obs_type[2:0]);
        end
    endtask

    task automatic test_freeze;
        pulse(1'b0, 1'b1, 1'b1);
        checks++;
        if (obs_pos !== {8'd40, 8'd159}) begin
            errors++;
            $display("FAIL over_with_tick got %h want 289f", obs_pos);
        end
        ticks(50, 8'h00);
        checks++;
        if (obs_pos !== {8'd40, 8'd159} || obs_active !== 2'b11 || speed !== 3'd1) begin
            errors++;
            $display("FAIL frozen_hold pos=%h act=%b spd=%0d want pos=289f act=11 spd=1", obs_pos, obs_active, speed);
        end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_active !== 2'b00 || obs_pos !== {8'd160, 8'd160} || speed !== 3'd1) begin
            errors++;
            $display("FAIL frozen_restart act=%b pos=%h spd=%0d want act=00 pos=a0a0 spd=1", obs_active, obs_pos, speed);
        end
        ticks(1, 8'h0A);
        checks++;
        if (obs_active !== 2'b01 || obs_pos[7:0] !== 8'd159) begin
            errors++;
            $display("FAIL restart_spawn act=%b pos0=%0d want act=01 pos0=159", obs_active, obs_pos[7:0]);
        end
    endtask

    task automatic test_simultaneous;
        pulse(1'b1, 1'b1, 1'b1);
        ticks(3, 8'h0A);
        checks++;
        if (obs_active !== 2'b01 || obs_pos[7:0] !== 8'd159) begin
            errors++;
            $display("FAIL run_over_wins act=%b pos0=%0d want act=01 pos0=159", obs_active, obs_pos[7:0]);
        end
        pulse(1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_active !== 2'b00 || obs_pos !== {8'd160, 8'd160}) begin
            errors++;
            $display("FAIL frozen_start_wins act=%b pos=%h want act=00 pos=a0a0", obs_active, obs_pos);
        end
        ticks(6, 8'h0A);
        checks++;
        if (obs_active !== 2'b01 || obs_pos[7:0] !== 8'd154) begin
            errors++;
            $display("FAIL run_after_both act=%b pos0=%0d want act=01 pos0=154", obs_active, obs_pos[7:0]);
        end
    endtask

    task automatic test_speed;
        pulse(1'b1, 1'b0, 1'b0);
`ifdef OBS_SPEEDUP_EN
        ticks(4, 8'h00);
        checks++;
        if (speed !== 3'd2) begin
            errors++;
            $display("FAIL ramp_4 got %0d want 2", speed);
        end
        ticks(8, 8'h00);
        checks++;
        if (speed !== 3'd4) begin
            errors++;
            $display("FAIL ramp_12 got %0d want 4", speed);
        end
        ticks(20, 8'h00);
        checks++;
        if (speed !== 3'd4) begin
            errors++;
            $display("FAIL ramp_cap got %0d want 4", speed);
        end
`else
        ticks(30, 8'h00);
        checks++;
        if (speed !== 3'd1 || obs_pos[7:0] !== 8'd130) begin
            errors++;
            $display("FAIL fixed_speed spd=%0d pos0=%0d want spd=1 pos0=130", speed, obs_pos[7:0]);
        end
`endif
    endtask

    task automatic test_async_reset;
        pulse(1'b1, 1'b0, 1'b0);
        ticks(3, 8'h0A);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_active !== 2'b00 || obs_pos !== {8'd160, 8'd160} || obs_type !== 6'd0 || speed !== 3'd1) begin
            errors++;
            $display("FAIL async_reset act=%b pos=%h type=%h spd=%0d want act=00 pos=a0a0 type=00 spd=1",
                     obs_active, obs_pos, obs_type, speed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ticks(5, 8'h0A);
        checks++;
        if (obs_active !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset act=%b want 00", obs_active);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_full_slots();
        test_freeze();
        test_simultaneous();
        test_speed();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
